// File: rtl/mlam_pkg.sv
// mlam_pkg: shared mode encoding, sizing and lane-packing helpers for the multiplier
package mlam_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  // number of product columns for a given operand width
  function automatic int cols(input int w);
    return 2 * w;
  endfunction

  // bit offset of lane c when each lane occupies w bits
  function automatic int lane_off(input int c, input int w);
    return c * w;
  endfunction

  // three-input majority gate; maj(x,y,0)=AND, maj(x,y,1)=OR
  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/mlam_lane_mult.sv
// mlam_lane_mult: one lane, pp generation/low-column OR (front) and final compression (back)
module mlam_lane_mult
  import mlam_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 6,
  parameter int SPLIT       = WIDTH / 2
) (
  input  logic [WIDTH-1:0]         a_i,
  input  logic [WIDTH-1:0]         b_i,
  input  logic                     mode_i,
  output logic [3*cols(WIDTH)-1:0] part_o,
  input  logic [3*cols(WIDTH)-1:0] part_i,
  output logic [cols(WIDTH)-1:0]   p_o
);

  localparam int PW = cols(WIDTH);

  logic [PW-1:0] hi0, hi1, lo, row;
  logic          pp, approx;

  assign approx = mode_i == MODE_APPROX;

  // rows below SPLIT and rows from SPLIT up are summed separately; the
  // approximated low columns are OR-ed and kept apart so no carry leaves them
  always_comb begin
    hi0 = '0;
    hi1 = '0;
    lo  = '0;
    row = '0;
    pp  = 1'b0;
    for (int j = 0; j < WIDTH; j++) begin
      row = '0;
      for (int i = 0; i < WIDTH; i++) begin
        pp = maj(a_i[i], b_i[j], 1'b0);
        if (approx && (i + j) < APPROX_COLS) lo[i+j] = maj(lo[i+j], pp, 1'b1);
        else row[i+j] = pp;
      end
      if (j < SPLIT) hi0 = hi0 + row;
      else hi1 = hi1 + row;
    end
  end

  assign part_o = {lo, hi1, hi0};

  // hi parts are multiples of 2^APPROX_COLS in approx mode, so adding lo never carries
  assign p_o = part_i[PW-1:0] + part_i[2*PW-1:PW] + part_i[3*PW-1:2*PW];

endmodule

// File: rtl/mlam_mult_pipe.sv
// mlam_mult_pipe: multi-lane pipelined exact/approximate multiplier with global-stall handshake
module mlam_mult_pipe
  import mlam_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NCH         = 3,
  parameter int APPROX_COLS = 6,
  parameter int STAGES      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_mode,
  input  logic [NCH*WIDTH-1:0]     in_a,
  input  logic [NCH*WIDTH-1:0]     in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NCH*2*WIDTH-1:0]   out_p,
  output logic [NCH*WIDTH-1:0]     out_msb,
  output logic                     out_mode,
  output logic [31:0]              beat_count
);

  localparam int PW = cols(WIDTH);
  localparam int LW = 3 * PW;
  localparam int N  = STAGES + 1;

  logic [NCH*LW-1:0] front_w;
  logic [NCH*LW-1:0] data_q [N];
  logic [N-1:0]      vld_q, mode_q;
  logic [31:0]       cnt_q, cnt_d;
  logic              adv;

  assign adv        = !vld_q[N-1] || out_ready;
  assign in_ready   = adv;
  assign out_valid  = vld_q[N-1];
  assign out_mode   = mode_q[N-1];
  assign beat_count = cnt_q;
  assign cnt_d      = cnt_q + ((out_valid && out_ready) ? 32'd1 : 32'd0);

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    mlam_lane_mult #(
      .WIDTH       (WIDTH),
      .APPROX_COLS (APPROX_COLS)
    ) u_lane (
      .a_i    (in_a[lane_off(c, WIDTH) +: WIDTH]),
      .b_i    (in_b[lane_off(c, WIDTH) +: WIDTH]),
      .mode_i (in_mode),
      .part_o (front_w[lane_off(c, LW) +: LW]),
      .part_i (data_q[N-1][lane_off(c, LW) +: LW]),
      .p_o    (out_p[lane_off(c, PW) +: PW])
    );
    assign out_msb[lane_off(c, WIDTH) +: WIDTH] = out_p[lane_off(c, PW) + WIDTH +: WIDTH];
  end

  // stage registers advance together; data only moves with a valid beat so
  // operands of idle cycles never reach the outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      mode_q <= {N{MODE_EXACT}};
      cnt_q  <= '0;
      for (int s = 0; s < N; s++) data_q[s] <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (adv) begin
        vld_q <= {vld_q[N-2:0], in_valid};
        if (in_valid) begin
          data_q[0] <= front_w;
          mode_q[0] <= in_mode;
        end
        for (int s = 1; s < N; s++) begin
          if (vld_q[s-1]) begin
            data_q[s] <= data_q[s-1];
            mode_q[s] <= mode_q[s-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mlam_mult_pipe.sv
// tb_mlam_mult_pipe: randomized self-checking bench against a column-count reference model
module tb_mlam_mult_pipe;

  typedef struct packed {
    logic [47:0] p;
    logic        m;
    logic [63:0] p2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b0;
  logic [23:0] in_a = '0, in_b = '0;
  logic [31:0] in_a2 = '0, in_b2 = '0;
  logic        in_ready, out_valid, out_mode;
  logic [47:0] out_p;
  logic [23:0] out_msb;
  logic [31:0] beat_count;
  logic        in_ready2, out_valid2, out_mode2;
  logic [63:0] out_p2;
  logic [31:0] out_msb2;
  logic [31:0] beat_count2;

  int   checks = 0, errors = 0;
  int   exp_count = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  mlam_mult_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .out_msb(out_msb), .out_mode(out_mode), .beat_count(beat_count)
  );

  mlam_mult_pipe #(.WIDTH(16), .NCH(2), .APPROX_COLS(0), .STAGES(2)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_mode(in_mode),
    .in_a(in_a2), .in_b(in_b2), .out_valid(out_valid2), .out_ready(out_ready), .out_p(out_p2),
    .out_msb(out_msb2), .out_mode(out_mode2), .beat_count(beat_count2)
  );

  // exact product minus the true weight of low-column partial products plus
  // one bit per low column that has any partial product set
  function automatic logic [31:0] golden(input logic [15:0] a, input logic [15:0] b,
                                         input logic m, input int w, input int k);
    logic [31:0] lowsum, lo;
    int cnt;
    lowsum = '0;
    lo = '0;
    if (m) begin
      for (int c = 0; c < k; c++) begin
        cnt = 0;
        for (int i = 0; i < w; i++)
          if (c - i >= 0 && c - i < w) if (a[i] && b[c-i]) cnt++;
        lowsum = lowsum + (32'(cnt) << c);
        if (cnt != 0) lo[c] = 1'b1;
      end
    end
    return 32'(a) * 32'(b) - lowsum + lo;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    e.m = in_mode;
    for (int c = 0; c < 3; c++)
      e.p[c*16 +: 16] = 16'(golden({8'h00, in_a[c*8 +: 8]}, {8'h00, in_b[c*8 +: 8]}, in_mode, 8, 6));
    for (int c = 0; c < 2; c++)
      e.p2[c*32 +: 32] = golden(in_a2[c*16 +: 16], in_b2[c*16 +: 16], in_mode, 16, 0);
    return e;
  endfunction

  function automatic logic [23:0] msb_of(input logic [47:0] p);
    logic [23:0] r;
    for (int c = 0; c < 3; c++) r[c*8 +: 8] = p[c*16 + 8 +: 8];
    return r;
  endfunction

  task automatic randomize_ops();
    in_mode = 1'($urandom);
    in_a = 24'($urandom);
    in_b = 24'($urandom);
    in_a2 = $urandom;
    in_b2 = $urandom;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_valid2 !== 1'b0)
      begin errors++; $display("FAIL reset_valid: got %b/%b want 0", out_valid, out_valid2); end
    checks++;
    if (out_p !== '0 || out_msb !== '0 || out_mode !== 1'b0 || out_p2 !== '0)
      begin errors++; $display("FAIL reset_data: got p=%h msb=%h m=%b want 0", out_p, out_msb, out_mode); end
    checks++;
    if (beat_count !== 32'd0)
      begin errors++; $display("FAIL reset_count: got %0d want 0", beat_count); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1)
      begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed(input logic [7:0] a, input logic [7:0] b, input logic m,
                               input logic [15:0] expv);
    exp_t e;
    @(negedge clk);
    out_ready = 1'b1;
    randomize_ops();
    in_mode = m;
    in_a[7:0] = a;
    in_b[7:0] = b;
    in_valid = 1'b1;
    #1;
    e = expect_now();
    checks++;
    if (in_ready !== 1'b1)
      begin errors++; $display("FAIL directed_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    randomize_ops();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0)
      begin errors++; $display("FAIL directed_early: out_valid %b one edge after accept, want 0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1)
      begin errors++; $display("FAIL directed_latency: out_valid %b two edges after accept, want 1", out_valid); end
    checks++;
    if (out_p[15:0] !== expv || out_msb[7:0] !== expv[15:8])
      begin errors++; $display("FAIL directed_lane0 a=%h b=%h m=%b: got p=%h msb=%h want p=%h msb=%h",
                               a, b, m, out_p[15:0], out_msb[7:0], expv, expv[15:8]); end
    checks++;
    if ({out_p, out_mode, out_p2} !== {e.p, e.m, e.p2})
      begin errors++; $display("FAIL directed_all: got p=%h m=%b p2=%h want p=%h m=%b p2=%h",
                               out_p, out_mode, out_p2, e.p, e.m, e.p2); end
    exp_count++;
  endtask

  task automatic test_stream(input int n, input int stall_at, input int stall_len, input bit rnd);
    int sent, cyc, first, last, low_ready;
    bit hold;
    logic [47:0] p_prev;
    exp_t e;
    sent = 0; cyc = 0; first = -1; last = -1; low_ready = 0; hold = 1'b0; p_prev = '0;
    while ((sent < n || q.size() != 0) && cyc < n * 8 + 100) begin
      @(negedge clk);
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= stall_at && cyc < stall_at + stall_len);
      randomize_ops();
      in_valid = (sent < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      #1;
      checks++;
      if (in_ready !== (!out_valid || out_ready) || out_valid2 !== out_valid)
        begin errors++; $display("FAIL stream_ready cyc %0d: in_ready=%b ov=%b ov16=%b or=%b",
                                 cyc, in_ready, out_valid, out_valid2, out_ready); end
      if (!in_ready) low_ready++;
      if (hold) begin
        checks++;
        if (out_p !== p_prev)
          begin errors++; $display("FAIL stall_hold cyc %0d: got %h want %h", cyc, out_p, p_prev); end
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          errors++; $display("FAIL stream_extra cyc %0d: unexpected beat p=%h", cyc, out_p);
        end else begin
          e = q.pop_front();
          checks++;
          if ({out_p, out_mode, out_p2} !== {e.p, e.m, e.p2} || out_msb !== msb_of(e.p))
            begin errors++; $display("FAIL stream_data cyc %0d: got p=%h msb=%h m=%b p2=%h want p=%h m=%b p2=%h",
                                     cyc, out_p, out_msb, out_mode, out_p2, e.p, e.m, e.p2); end
        end
        exp_count++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (in_valid && in_ready) begin
        q.push_back(expect_now());
        sent++;
      end
      hold = out_valid && !out_ready;
      p_prev = out_p;
      cyc++;
    end
    checks++;
    if (sent < n || q.size() != 0)
      begin errors++; $display("FAIL stream_timeout: sent %0d of %0d, %0d outstanding", sent, n, q.size()); end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (beat_count !== 32'(exp_count) || beat_count2 !== 32'(exp_count))
      begin errors++; $display("FAIL stream_count: got %0d/%0d want %0d", beat_count, beat_count2, exp_count); end
    if (!rnd && stall_len == 0) begin
      checks++;
      if (last - first != n - 1)
        begin errors++; $display("FAIL back_to_back_span: got %0d cycles want %0d", last - first + 1, n); end
    end
    if (stall_len > 0) begin
      checks++;
      if (low_ready == 0)
        begin errors++; $display("FAIL stall_in_ready: got 0 low cycles want >0"); end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    exp_count = 0;
    @(negedge clk);
    rst = 1'b0;
    test_stream(8, 0, 0, 1'b0);
    checks++;
    if (beat_count !== 32'd8)
      begin errors++; $display("FAIL back_to_back_count: got %0d want 8", beat_count); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    out_ready = 1'b0;
    randomize_ops();
    in_valid = 1'b1;
    @(negedge clk);
    randomize_ops();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    checks++;
    if (out_valid !== 1'b1 || beat_count === 32'd0)
      begin errors++; $display("FAIL async_pre: out_valid=%b count=%0d want 1 and nonzero", out_valid, beat_count); end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || beat_count !== 32'd0 || out_p !== '0 || out_p2 !== '0)
      begin errors++; $display("FAIL async_reset: got valid=%b count=%0d p=%h want 0", out_valid, beat_count, out_p); end
    q.delete();
    exp_count = 0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0)
        begin errors++; $display("FAIL async_flush: got out_valid %b want 0", out_valid); end
    end
    test_stream(6, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    test_directed(8'hFF, 8'hFF, 1'b1, 16'hFCFF);
    test_directed(8'h03, 8'h03, 1'b1, 16'h0007);
    test_directed(8'h03, 8'h03, 1'b0, 16'h0009);
    test_directed(8'h10, 8'h10, 1'b0, 16'h0100);
    test_directed(8'h10, 8'h10, 1'b1, 16'h0100);
    test_back_to_back();
    test_stream(20, 6, 5, 1'b0);
    test_async_reset();
    test_stream(10000, 0, 0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mlam_mult_pipe.md
Name: mlam_mult_pipe

Overview:
- Parametrised, pipelined, multi-channel unsigned multiplier for the image-processing datapath; successor to the fixed 8x8 combinational majority-logic multiplier.
- Each of NCH lanes, for example R/G/B, computes A*B in exact mode or in lower-part-OR approximate mode.
- Approximate mode uses majority gates with constant 1 (OR) in the low APPROX_COLS columns and suppresses carries out of those columns.
- Sits between the pixel reader and the image writer, with a valid/ready handshake on both sides and a transaction counter.

Parameters:
- WIDTH, 8, operand width per lane (4..16).
- NCH, 3, number of parallel lanes.
- APPROX_COLS, 6, number of low product columns approximated; range 0..2*WIDTH-1.
- STAGES, 2, pipeline register stages (1..4); latency = STAGES cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_mode  in  1  0 = exact, 1 = approximate; sampled with the beat.
- in_a  in  NCH*WIDTH  lane operand A, lane c at bits [c*WIDTH +: WIDTH].
- in_b  in  NCH*WIDTH  lane operand B, same packing.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_p  out  NCH*2*WIDTH  full product per lane, lane c at [c*2*WIDTH +: 2*WIDTH].
- out_msb  out  NCH*WIDTH  upper WIDTH bits of each lane product, for direct pixel write.
- out_mode  out  1  mode tag travelling with the result.
- beat_count  out  32  count of accepted output beats.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: all stage valid bits 0, out_valid 0, out_p 0, out_msb 0, out_mode 0, beat_count 0. in_ready is 1 after reset.
- Arithmetic, per lane, with K = APPROX_COLS:
  - pp(i,j) = a[i] & b[j], formed with majority(a,b,0).
  - Exact mode: P = a*b, 2*WIDTH bits.
  - Approx mode: P = sum over i+j>=K of pp(i,j)*2^(i+j), plus sum over k<K of 2^k * OR over i+j=k of pp(i,j).
  - OR is formed with majority(x,y,1). No carry passes from column K-1 into column K.
  - K=0 in approx mode equals exact mode.
  - Result always fits 2*WIDTH bits; no overflow possible.
- out_msb lane c = out_p lane c [2*WIDTH-1 : WIDTH].
- Pipeline:
  - Partial-product generation and column compression are split across STAGES registered stages.
  - A beat accepted at edge n produces out_valid at edge n+STAGES when there is no stall.
  - Mode and all lanes travel together in lockstep.
- Handshake:
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - Global-stall pipeline: advance = !out_valid || out_ready. in_ready = advance (combinational).
  - When advance is 0, every stage holds its data and valid bit.
  - out_p, out_msb and out_mode are stable while out_valid && !out_ready.
  - Simultaneous input and output transfer in the same cycle is supported at full throughput (1 beat per cycle).
  - in_valid low while advancing inserts a bubble: the stage valid bit becomes 0 and the data register may hold stale data.
- beat_count: increments by 1 on each output transfer and wraps from 0xFFFFFFFF to 0.
- Reset mid-operation: all in-flight beats are discarded, and no out_valid is asserted until a new beat traverses STAGES cycles.
- Operands and mode are don't-care when in_valid=0; they must not affect outputs.

Decomposition:
- Shared package mlam_pkg holds:
  - mode encoding constants MODE_EXACT=0, MODE_APPROX=1;
  - a function giving the column count for a given WIDTH;
  - the bit-packing offset helpers for lanes.
- Reuse the existing majority primitive.
- One sub-module, mlam_lane_mult: one lane, combinational pp/column logic with WIDTH/APPROX_COLS parameters, split by a stage-boundary parameter. mlam_mult_pipe instantiates NCH lanes plus the shared valid/stall/counter control.

Test Plan:
- Defaults, exact mode, lane0 a=0xFF b=0xFF -> out_p lane0 = 0xFE01, out_msb = 0xFE, out_valid 2 cycles after acceptance.
- Approx mode, a=0xFF b=0xFF -> 0xFCFF; a=0x03 b=0x03 -> 0x0007 (exact value 0x0009); a=0x10 b=0x10 -> 0x0100 in both modes.
- Stream of 8 back-to-back beats with out_ready=1 -> 8 results in order on consecutive cycles, beat_count=8.
- out_ready held 0 for 5 cycles mid-stream:
  - in_ready drops once the output holds valid data;
  - out_p stays stable during the stall;
  - no beat is lost or duplicated after release.
- Assert rst asynchronously between clock edges with 2 beats in flight -> out_valid and beat_count go to 0 immediately; after release, only new beats appear.
- Random operands and modes on 3 lanes, 10k beats, compared against the golden formula -> zero mismatches. Repeat with APPROX_COLS=0 (approx equals exact) and WIDTH=16.
